multi_echo_ranger: RTL and testbench
====================================

// Module: multi_echo_ranger
// PURPOSE
//  Multi-channel ultrasonic echo-pulse ranger. Measures the high width of each sensor echo
//  (sensout) and converts it to distance by counting groups of K clock cycles, so no
//  divider is needed. Adds per-channel enable, echo timeout, saturation, too-close flag and
//  a registered nearest-object result for the crash-detection top level.
// PARAMETERS
//  NCH      4        number of sensor channels
//  DIST_W   9        distance width, units of K cycles
//  K        2700     clock cycles per distance unit (K >= 2)
//  MAX_DIST 500      saturation distance (< 2**DIST_W)
//  MIN_DIST 10       too_close threshold (distance < MIN_DIST)
//  TIMEOUT  1000000  cycles in WAIT_HIGH before no-echo fault (>= 2)
//  CNT_W    24       width of prescaler/timeout counters (2**CNT_W > max(K,TIMEOUT))
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             asynchronous reset, active-low (0 = reset)
//  en           in   NCH           per-channel measurement enable, level
//  sensout      in   NCH           raw asynchronous echo inputs
//  distance     out  NCH*DIST_W    ch i at [i*DIST_W +: DIST_W], held between results
//  dist_valid   out  NCH           1-cycle pulse: new result on channel i
//  too_close    out  NCH           level, updated with dist_valid
//  fault        out  NCH           level, 1 = last result was timeout (no echo)
//  nearest_dist out  DIST_W        smallest good distance over all channels
//  nearest_ch   out  $clog2(NCH)   channel of nearest_dist (lowest index on tie)
// BEHAVIOUR
//  Reset (rst=0, async): all channels IDLE; distance, dist_valid, too_close, fault,
//   nearest_ch = 0; nearest_dist = MAX_DIST; have_data[i] = 0; sync flops = 0.
//  sensout passes through a 2-flop synchroniser per channel; s = synchronised sample.
//  Per-channel FSM, all channels independent:
//   IDLE:      en[i]=1 -> WAIT_HIGH (wait counter = 0).
//   WAIT_HIGH: s=1 -> MEASURE, prescaler = 1, dist counter = 0 (this sample counts);
//              else wait counter++; at TIMEOUT-1 -> DONE with timeout=1.
//   MEASURE:   s=1: prescaler++; when prescaler reaches K -> prescaler = 1... correctly:
//              on the sample that makes N high samples a multiple of K, dist counter++.
//              Result = min(floor(N/K), MAX_DIST); dist counter reaching MAX_DIST -> DONE
//              with sat=1. s=0 -> DONE (sat=0).
//   DONE (1 cycle): distance[i] <= dist counter (MAX_DIST if timeout); dist_valid[i]=1;
//              too_close[i] <= !timeout & (dist < MIN_DIST); fault[i] <= timeout;
//              have_data[i] <= !timeout. Next: s=1 -> WAIT_LOW, else IDLE.
//   WAIT_LOW:  s=0 -> IDLE (prevents re-measuring a stuck or saturated echo).
//  en[i]=0 in WAIT_HIGH/MEASURE/WAIT_LOW -> IDLE next cycle, no dist_valid, outputs held.
//  en[i]=0 in DONE: DONE completes (result published), then IDLE.
//  Latency: dist_valid asserts in the 2nd clock after the first s=0 sample in MEASURE
//   (FSM registers DONE, outputs registered in DONE); ~4 clk from raw falling edge.
//  Nearest: registered, recomputed every cycle from distance[] masked by have_data;
//   valid one cycle after dist_valid. No have_data -> MAX_DIST, ch 0. Ties: lowest index.
//  Simultaneous dist_valid on several channels: all published same cycle, no loss.
//  Counters never wrap: prescaler bounded by K, dist by MAX_DIST, wait by TIMEOUT.
// TESTING
//  1 K=4, ch0 en, echo high 43 cycles -> distance0=10, dist_valid0 1 cycle, too_close0=0.
//  2 K=4, ch1 echo high 39 cycles -> distance1=9, too_close1=1; nearest_dist=9, ch=1.
//  3 TIMEOUT=50, ch2 en, no echo -> after 50 WAIT_HIGH cycles dist_valid2, fault2=1,
//    distance2=MAX_DIST, excluded from nearest.
//  4 K=4,MAX_DIST=20, ch3 echo held high 200 cycles -> valid at 80th high sample,
//    distance3=20; no further valid until echo low then new echo.
//  5 en0 dropped mid-MEASURE -> no dist_valid0, distance0 unchanged; async rst=0 mid-echo
//    -> all outputs reset immediately, nearest_dist=MAX_DIST.
//  6 ch0 and ch2 echoes end same cycle with 12 and 12 -> both valid, nearest_ch=0.

Source files
------------

// File: rtl/multi_echo_ranger.sv
// Multi-channel ultrasonic echo ranger: echo width -> distance in K-cycle units,
// with timeout, saturation, too-close flag and a registered nearest-object result.
module multi_echo_ranger #(
   parameter int NCH      = 4,
   parameter int DIST_W   = 9,
   parameter int K        = 2700,
   parameter int MAX_DIST = 500,
   parameter int MIN_DIST = 10,
   parameter int TIMEOUT  = 1000000,
   parameter int CNT_W    = 24,
   localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        en,
   input  logic [NCH-1:0]        sensout,
   output logic [NCH*DIST_W-1:0] distance,
   output logic [NCH-1:0]        dist_valid,
   output logic [NCH-1:0]        too_close,
   output logic [NCH-1:0]        fault,
   output logic [DIST_W-1:0]     nearest_dist,
   output logic [CH_W-1:0]       nearest_ch
);

   typedef enum logic [2:0] {
      IDLE, WAIT_HIGH, MEASURE, DONE, WAIT_LOW
   } state_t;

   localparam logic [CNT_W-1:0]  K_LAST  = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [DIST_W-1:0] D_MAX   = DIST_W'(MAX_DIST);
   localparam logic [DIST_W-1:0] D_SAT   = DIST_W'(MAX_DIST - 1);
   localparam logic [DIST_W-1:0] D_MIN   = DIST_W'(MIN_DIST);

   logic [NCH-1:0]    sync1;
   logic [NCH-1:0]    sync2;
   logic [NCH-1:0]    have_data;
   logic [NCH-1:0]    tmo;
   state_t            state    [NCH];
   logic [CNT_W-1:0]  pre      [NCH];
   logic [CNT_W-1:0]  wait_cnt [NCH];
   logic [DIST_W-1:0] dcnt     [NCH];

   logic [DIST_W-1:0] best;
   logic [CH_W-1:0]   best_ch;
   logic              found;

   // Two-flop synchroniser for the raw echo inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sensout;
         sync2 <= sync1;
      end
   end

   // Per-channel measurement FSM; results are registered while in DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            state[i]    <= IDLE;
            pre[i]      <= '0;
            wait_cnt[i] <= '0;
            dcnt[i]     <= '0;
         end
         tmo        <= '0;
         have_data  <= '0;
         distance   <= '0;
         dist_valid <= '0;
         too_close  <= '0;
         fault      <= '0;
      end else begin
         dist_valid <= '0;
         for (int i = 0; i < NCH; i++) begin
            unique case (state[i])
               IDLE: begin
                  if (en[i]) begin
                     state[i]    <= WAIT_HIGH;
                     wait_cnt[i] <= '0;
                     tmo[i]      <= 1'b0;
                  end
               end
               WAIT_HIGH: begin
                  if (!en[i]) begin
                     state[i] <= IDLE;
                  end else if (sync2[i]) begin
                     state[i] <= MEASURE;
                     pre[i]   <= CNT_W'(1);
                     dcnt[i]  <= '0;
                  end else if (wait_cnt[i] == TO_LAST) begin
                     state[i] <= DONE;
                     tmo[i]   <= 1'b1;
                  end else begin
                     wait_cnt[i] <= wait_cnt[i] + 1'b1;
                  end
               end
               MEASURE: begin
                  if (!en[i]) begin
                     state[i] <= IDLE;
                  end else if (!sync2[i]) begin
                     state[i] <= DONE;
                  end else if (pre[i] == K_LAST) begin
                     pre[i]  <= '0;
                     dcnt[i] <= dcnt[i] + 1'b1;
                     if (dcnt[i] == D_SAT)
                        state[i] <= DONE;
                  end else begin
                     pre[i] <= pre[i] + 1'b1;
                  end
               end
               DONE: begin
                  distance[i*DIST_W +: DIST_W] <= tmo[i] ? D_MAX : dcnt[i];
                  dist_valid[i] <= 1'b1;
                  too_close[i]  <= !tmo[i] && (dcnt[i] < D_MIN);
                  fault[i]      <= tmo[i];
                  have_data[i]  <= !tmo[i];
                  state[i]      <= sync2[i] ? WAIT_LOW : IDLE;
               end
               WAIT_LOW: begin
                  if (!en[i] || !sync2[i])
                     state[i] <= IDLE;
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

   // Smallest good distance, lowest channel index wins ties
   always_comb begin
      best    = D_MAX;
      best_ch = '0;
      found   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (have_data[i] &&
             (!found || distance[i*DIST_W +: DIST_W] < best)) begin
            best    = distance[i*DIST_W +: DIST_W];
            best_ch = CH_W'(i);
            found   = 1'b1;
         end
      end
   end

   // Nearest-object result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nearest_dist <= D_MAX;
         nearest_ch   <= '0;
      end else begin
         nearest_dist <= best;
         nearest_ch   <= best_ch;
      end
   end

endmodule

// File: tb/tb_multi_echo_ranger.sv
// Scoreboard bench for multi_echo_ranger: directed scenarios plus
// randomized concurrent echoes checked against an event-level model.
module tb_multi_echo_ranger;

   localparam int NCH  = 4;
   localparam int DW   = 9;
   localparam int K    = 4;
   localparam int MAXD = 20;
   localparam int MIND = 10;
   localparam int TMO  = 50;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NCH-1:0]  en = '0;
   logic [NCH-1:0]  sensout = '0;
   logic [NCH*DW-1:0] distance;
   logic [NCH-1:0]  dist_valid;
   logic [NCH-1:0]  too_close;
   logic [NCH-1:0]  fault;
   logic [DW-1:0]   nearest_dist;
   logic [1:0]      nearest_ch;

   multi_echo_ranger #(
      .NCH(NCH), .DIST_W(DW), .K(K), .MAX_DIST(MAXD),
      .MIN_DIST(MIND), .TIMEOUT(TMO), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sensout(sensout),
      .distance(distance), .dist_valid(dist_valid),
      .too_close(too_close), .fault(fault),
      .nearest_dist(nearest_dist), .nearest_ch(nearest_ch)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int d;
      int tc;
      int f;
      int t;
   } exp_t;

   exp_t q [NCH][$];
   int md  [NCH];
   int mtc [NCH];
   int mf  [NCH];
   int mh  [NCH];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic void chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endfunction

   function automatic int dist_of(int h);
      return (h >= K * MAXD) ? MAXD : h / K;
   endfunction

   function automatic int lat_of(int h);
      return (h >= K * MAXD) ? K * MAXD + 3 : h + 4;
   endfunction

   function automatic int dout(int ch);
      logic [NCH*DW-1:0] v;
      v = distance >> (ch * DW);
      return int'(v[DW-1:0]);
   endfunction

   // Monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            md[c] = 0; mtc[c] = 0; mf[c] = 0; mh[c] = 0;
         end
      end else begin
         int ed, ec;
         bit fnd;
         exp_t e;
         ed = MAXD; ec = 0; fnd = 0;
         for (int c = 0; c < NCH; c++)
            if (mh[c] != 0 && (!fnd || md[c] < ed)) begin
               ed = md[c]; ec = c; fnd = 1;
            end
         chk("nearest_dist", int'(nearest_dist), ed);
         chk("nearest_ch", int'(nearest_ch), ec);
         for (int c = 0; c < NCH; c++) begin
            if (dist_valid[c]) begin
               if (q[c].size() == 0) begin
                  tests++;
                  errors++;
                  $display("FAIL unexpected_valid ch%0d: got dist_valid=1 required 0",
                           c);
               end else begin
                  e = q[c].pop_front();
                  chk($sformatf("dist_ch%0d", c), dout(c), e.d);
                  chk($sformatf("too_close_ch%0d", c), int'(too_close[c]), e.tc);
                  chk($sformatf("fault_ch%0d", c), int'(fault[c]), e.f);
                  chk($sformatf("latency_ch%0d", c), cyc, e.t);
                  md[c] = e.d; mtc[c] = e.tc; mf[c] = e.f;
                  mh[c] = (e.f == 0) ? 1 : 0;
               end
            end
            chk($sformatf("held_dist_ch%0d", c), dout(c), md[c]);
            chk($sformatf("held_tc_ch%0d", c), int'(too_close[c]), mtc[c]);
            chk($sformatf("held_fault_ch%0d", c), int'(fault[c]), mf[c]);
         end
      end
   end

   task automatic pulse(input int ch, input int h, input int gap);
      exp_t e;
      int d;
      @(posedge clk); #1;
      en[ch] = 1'b1;
      repeat (gap + 1) @(posedge clk);
      #1;
      sensout[ch] = 1'b1;
      d = dist_of(h);
      e.d = d;
      e.tc = (d < MIND) ? 1 : 0;
      e.f = 0;
      e.t = cyc + lat_of(h);
      q[ch].push_back(e);
      repeat (h) @(posedge clk);
      #1;
      sensout[ch] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      en[ch] = 1'b0;
   endtask

   task automatic no_echo(input int ch);
      exp_t e;
      @(posedge clk); #1;
      en[ch] = 1'b1;
      e.d = MAXD; e.tc = 0; e.f = 1; e.t = cyc + TMO + 2;
      q[ch].push_back(e);
      repeat (TMO + 10) @(posedge clk);
      #1;
      en[ch] = 1'b0;
   endtask

   task automatic rand_chan(input int ch, input int n);
      for (int j = 0; j < n; j++) begin
         if ($urandom_range(0, 5) == 0)
            no_echo(ch);
         else
            pulse(ch, int'($urandom_range(1, 100)), int'($urandom_range(0, 8)));
         repeat ($urandom_range(0, 5)) @(posedge clk);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int c = 0; c < NCH; c++) begin
         chk({tag, "_dist"}, dout(c), 0);
         chk({tag, "_valid"}, int'(dist_valid[c]), 0);
         chk({tag, "_tc"}, int'(too_close[c]), 0);
         chk({tag, "_fault"}, int'(fault[c]), 0);
      end
      chk({tag, "_nearest_dist"}, int'(nearest_dist), MAXD);
      chk({tag, "_nearest_ch"}, int'(nearest_ch), 0);
   endtask

   initial begin
      exp_t e;
      int budget;
      bit busy;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b1;
      repeat (2) @(posedge clk);

      pulse(0, 43, 2);
      chk("t1_dist0", dout(0), 10);
      chk("t1_tc0", int'(too_close[0]), 0);

      pulse(1, 39, 3);
      chk("t2_dist1", dout(1), 9);
      chk("t2_tc1", int'(too_close[1]), 1);
      chk("t2_nearest_dist", int'(nearest_dist), 9);
      chk("t2_nearest_ch", int'(nearest_ch), 1);

      no_echo(2);
      chk("t3_fault2", int'(fault[2]), 1);
      chk("t3_dist2", dout(2), MAXD);
      chk("t3_nearest_ch", int'(nearest_ch), 1);

      pulse(3, 200, 1);
      chk("t4_dist3", dout(3), MAXD);

      @(posedge clk); #1;
      en[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sensout[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      en[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      sensout[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t5_dist0_held", dout(0), 10);

      en[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sensout[1] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_state("midrst");
      en = '0;
      sensout = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      @(posedge clk); #1;
      en[0] = 1'b1;
      en[2] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sensout[0] = 1'b1;
      sensout[2] = 1'b1;
      e.d = 12; e.tc = 0; e.f = 0; e.t = cyc + 48 + 4;
      q[0].push_back(e);
      q[2].push_back(e);
      repeat (48) @(posedge clk);
      #1;
      sensout[0] = 1'b0;
      sensout[2] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      en[0] = 1'b0;
      en[2] = 1'b0;
      chk("t6_nearest_dist", int'(nearest_dist), 12);
      chk("t6_nearest_ch", int'(nearest_ch), 0);

      fork
         rand_chan(0, 10);
         rand_chan(1, 10);
         rand_chan(2, 10);
         rand_chan(3, 10);
      join

      budget = 0;
      busy = 1;
      while (busy && budget < 300) begin
         busy = 0;
         for (int c = 0; c < NCH; c++)
            if (q[c].size() != 0) busy = 1;
         if (busy) begin
            @(posedge clk);
            budget++;
         end
      end
      for (int c = 0; c < NCH; c++)
         chk($sformatf("pending_ch%0d", c), q[c].size(), 0);
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
